yc_niu_rx_sink: RTL and testbench
=================================

Name: yc_niu_rx_sink

Overview:
- Receive-side NIU endpoint: the consumer end of the valid/ready flit link that yc_niu_skel drives as transmitter.
- Attaches to a router local output port (l_out_*) or any link output.
- Generates a programmable ready/backpressure pattern, accepts flits, and checks per-source sequence numbers carried in the flit.
- Exposes accept/error counters and first-error capture, so router and skid benches can measure throughput under downstream stall.

Parameters:
- FLIT_W, 64: flit width in bits; rx_flit is a flat vector (a flit_t cast fits).
- SRC_LSB, 56: LSB of the source-id field within the flit.
- SRC_W, 2: source-id width; NUM_SRC = 2**SRC_W tracked sources.
- SEQ_LSB, 0: LSB of the sequence-number field.
- SEQ_W, 16: sequence-number width; arithmetic is modulo 2**SEQ_W.
- READY_ON, 4: cycles ready is held high per period (must be >= 1).
- READY_OFF, 0: cycles ready is held low per period; 0 means always ready while enabled.
- CNT_W, 32: accept-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  sink enable; when low, ready is forced low
- rx_valid  in  1  flit valid from link
- rx_flit  in  FLIT_W  flit data
- rx_ready  out  1  sink ready (registered)
- rx_count  out  CNT_W  accepted flits, saturating
- err_count  out  16  sequence errors, saturating
- err_valid  out  1  sticky; set on the first sequence error
- err_src  out  SRC_W  source id of the first error
- err_exp  out  SEQ_W  expected sequence number at the first error
- err_got  out  SEQ_W  received sequence number at the first error
- active  out  1  FSM is not in IDLE

Behaviour:
- Reset (clk edge with rst_n=0): all outputs 0, FSM=IDLE, period counter 0, all per-source seen bits 0, all expected sequence numbers 0.
- Handshake: a flit is accepted when rx_valid && rx_ready at a posedge.
  - rx_ready is a register output; it never combinationally depends on rx_valid.
  - The sink never drops a flit presented while ready is high.
- FSM states IDLE, ON, OFF; rx_ready = (state==ON).
  - IDLE: if en=1, go to ON with the counter loaded to READY_ON-1.
  - ON: if en=0, go to IDLE. Otherwise, if the counter is 0 and READY_OFF>0, go to OFF with the counter loaded to READY_OFF-1. If the counter is 0 and READY_OFF=0, stay in ON and reload. Otherwise decrement.
  - OFF: if en=0, go to IDLE. Otherwise, when the counter is 0, go to ON and reload READY_ON-1; else decrement.
- en dropping: a handshake on the same edge that en falls is still counted and checked. rx_ready is low from the next cycle.
- Result latency: counters and error registers update on the same edge as the accepting handshake; new values are visible the following cycle.
- Sequence check on accept, with s = flit[SRC_LSB +: SRC_W] and q = flit[SEQ_LSB +: SEQ_W]:
  - If seen[s]=0: set seen[s], set exp[s]=q+1, no error (seeding).
  - Else if q==exp[s]: set exp[s]=q+1.
  - Else (mismatch): err_count+1 (saturate at 16'hFFFF), resync exp[s]=q+1. If err_valid=0, latch err_src, err_exp, err_got and set err_valid.
  - Sequence wrap: exp = 2**SEQ_W-1 followed by q=0 is not an error.
- rx_count increments per accept and saturates at all-ones; it does not wrap.
- The first-error capture fields are never overwritten until reset.
- Reset mid-operation: everything returns to reset values, including the seen bits. The first flit after reset re-seeds and is not an error.

Optional Feature:
- Macro: YC_NIU_RX_LFSR_STALL_EN.
- With the macro defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - In ON and OFF the per-period counter is replaced: the next state is ON when lfsr[1:0]!=2'b00, else OFF. This gives roughly 75% ready.
  - READY_ON and READY_OFF are ignored; IDLE and en behaviour is unchanged.
- Without the macro: no LFSR logic, and the deterministic periodic pattern applies.

Test Plan:
- READY_OFF=0, en=1, yc_niu_skel source 0 sends seq 0..99 continuously -> rx_ready constant 1 after 1 cycle; rx_count=100; err_count=0; err_valid=0.
- READY_ON=2, READY_OFF=3, continuous source for 1000 cycles after ready first rises -> rx_ready pattern 11000 repeating; rx_count=400; no flit lost or duplicated (sequence clean).
- Source 1 sends seq 5,6,8,9 -> err_count=1; err_valid=1; err_src=1; err_exp=8'd7 (i.e. 16'd7); err_got=16'd8; second flit gap later does not change the err_* capture fields.
- SEQ_W=16, source 2 sends 16'hFFFE,16'hFFFF,0,1 -> err_count=0; rx_count=4.
- en dropped for 10 cycles mid-stream with rx_valid held high -> rx_ready=0 during that window; the flit accepted on the en-fall edge is counted; no errors after resume.
- rst_n pulsed low mid-stream, then source 0 resumes at seq 50 -> counters read 0 after reset, seq 50 seeds with no error, and rx_count increments from 1.

Source files
------------

// File: rtl/yc_niu_rx_sink.sv
//==============================================================================
//  Module   : yc_niu_rx_sink
//  Purpose  : Receive-side NIU endpoint. Consumer end of a valid/ready flit
//             link. Drives a programmable ready/backpressure pattern, accepts
//             flits, checks per-source sequence numbers carried in each flit,
//             and exposes saturating accept/error counters plus capture of the
//             first sequence error.
//
//  Ports    : clk        - clock
//             rst_n      - synchronous, active-low reset
//             en         - sink enable; ready is forced low while en is low
//             rx_valid   - flit valid from the link
//             rx_flit    - flit data (flat vector, FLIT_W bits)
//             rx_ready   - sink ready (registered, independent of rx_valid)
//             rx_count   - accepted flits, saturating at all-ones
//             err_count  - sequence errors, saturating at 16'hFFFF
//             err_valid  - sticky flag, set on the first sequence error
//             err_src    - source id of the first error
//             err_exp    - expected sequence number at the first error
//             err_got    - received sequence number at the first error
//             active     - ready-pattern FSM is not idle
//
//  Options  : YC_NIU_RX_LFSR_STALL_EN - when defined, the periodic READY_ON /
//             READY_OFF pattern is replaced by a pseudo-random pattern from a
//             16-bit Fibonacci LFSR (about 75% ready). Default: undefined.
//
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module yc_niu_rx_sink #(
    parameter int FLIT_W    = 64,
    parameter int SRC_LSB   = 56,
    parameter int SRC_W     = 2,
    parameter int SEQ_LSB   = 0,
    parameter int SEQ_W     = 16,
    parameter int READY_ON  = 4,
    parameter int READY_OFF = 0,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rx_valid,
    input  logic [FLIT_W-1:0] rx_flit,
    output logic              rx_ready,
    output logic [CNT_W-1:0]  rx_count,
    output logic [15:0]       err_count,
    output logic              err_valid,
    output logic [SRC_W-1:0]  err_src,
    output logic [SEQ_W-1:0]  err_exp,
    output logic [SEQ_W-1:0]  err_got,
    output logic              active
);

    localparam int c_num_src = 2 ** SRC_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Ready-pattern FSM. rx_ready and active are registered copies of the
    // next state so that ready never depends combinationally on rx_valid.
    // -------------------------------------------------------------------------
    state_t state_q;
    logic   ready_q;
    logic   active_q;

`ifdef YC_NIU_RX_LFSR_STALL_EN

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
    logic [15:0] lfsr_q;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q  <= ST_ON;
                        ready_q  <= 1'b1;
                        active_q <= 1'b1;
                    end
                end
                ST_ON, ST_OFF: begin
                    if (!en) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b0;
                        active_q <= 1'b0;
                    end else if (lfsr_q[1:0] != 2'b00) begin
                        state_q <= ST_ON;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_OFF;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ready_q  <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

`else

    // Period counter holds the remaining cycles of the current ON/OFF phase
    // minus one, so a phase ends when the counter reads zero.
    localparam int c_per_max = (READY_ON > READY_OFF) ? READY_ON : READY_OFF;
    localparam int c_per_w   = (c_per_max > 1) ? $clog2(c_per_max) : 1;

    localparam logic [c_per_w-1:0] c_on_reload  = c_per_w'(READY_ON - 1);
    localparam logic [c_per_w-1:0] c_off_reload =
        (READY_OFF > 0) ? c_per_w'(READY_OFF - 1) : '0;
    localparam logic [c_per_w-1:0] c_per_one    = c_per_w'(1);

    logic [c_per_w-1:0] per_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            ready_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q   <= ST_ON;
                        per_cnt_q <= c_on_reload;
                        ready_q   <= 1'b1;
                        active_q  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (!en) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b0;
                        active_q <= 1'b0;
                    end else if (per_cnt_q == '0) begin
                        // READY_OFF of zero means the sink stays ready forever.
                        if (READY_OFF > 0) begin
                            state_q   <= ST_OFF;
                            per_cnt_q <= c_off_reload;
                            ready_q   <= 1'b0;
                        end else begin
                            per_cnt_q <= c_on_reload;
                        end
                    end else begin
                        per_cnt_q <= per_cnt_q - c_per_one;
                    end
                end
                ST_OFF: begin
                    if (!en) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b0;
                        active_q <= 1'b0;
                    end else if (per_cnt_q == '0) begin
                        state_q   <= ST_ON;
                        per_cnt_q <= c_on_reload;
                        ready_q   <= 1'b1;
                    end else begin
                        per_cnt_q <= per_cnt_q - c_per_one;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    per_cnt_q <= '0;
                    ready_q   <= 1'b0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

`endif

    // -------------------------------------------------------------------------
    // Accept path and per-source sequence checker.
    // The handshake uses the registered ready, so a flit accepted on the same
    // edge that en falls is still counted and checked.
    // -------------------------------------------------------------------------
    logic             w_accept;
    logic [SRC_W-1:0] w_src;
    logic [SEQ_W-1:0] w_seq;
    logic [SEQ_W-1:0] w_seq_next;
    logic [SEQ_W-1:0] w_exp_cur;
    logic             w_mismatch;
    logic             w_unused_flit;

    logic [c_num_src-1:0] seen_q, seen_d;
    logic [SEQ_W-1:0]     exp_q [c_num_src];
    logic [SEQ_W-1:0]     exp_d [c_num_src];

    logic [CNT_W-1:0] rx_count_q,  rx_count_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             err_valid_q, err_valid_d;
    logic [SRC_W-1:0] err_src_q,   err_src_d;
    logic [SEQ_W-1:0] err_exp_q,   err_exp_d;
    logic [SEQ_W-1:0] err_got_q,   err_got_d;

    assign w_accept   = rx_valid && ready_q;
    assign w_src      = rx_flit[SRC_LSB +: SRC_W];
    assign w_seq      = rx_flit[SEQ_LSB +: SEQ_W];
    // Modulo-2**SEQ_W increment: the all-ones value wraps cleanly to zero.
    assign w_seq_next = w_seq + SEQ_W'(1);
    assign w_exp_cur  = exp_q[w_src];
    // An unseen source seeds its expectation and can never mismatch.
    assign w_mismatch = w_accept && seen_q[w_src] && (w_seq != w_exp_cur);

    // Only the source and sequence fields are inspected; the rest of the flit
    // is payload that this endpoint discards.
    assign w_unused_flit = ^rx_flit;

    always_comb begin
        seen_d      = seen_q;
        exp_d       = exp_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        err_valid_d = err_valid_q;
        err_src_d   = err_src_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;

        if (w_accept) begin
            // Seed, match and mismatch all (re)synchronise to q+1.
            seen_d[w_src] = 1'b1;
            exp_d[w_src]  = w_seq_next;

            if (rx_count_q != {CNT_W{1'b1}}) begin
                rx_count_d = rx_count_q + CNT_W'(1);
            end

            if (w_mismatch) begin
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                // Capture only the very first error; later ones leave it alone.
                if (!err_valid_q) begin
                    err_valid_d = 1'b1;
                    err_src_d   = w_src;
                    err_exp_d   = w_exp_cur;
                    err_got_d   = w_seq;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q      <= '0;
            for (int i = 0; i < c_num_src; i++) begin
                exp_q[i] <= '0;
            end
            rx_count_q  <= '0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            err_src_q   <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
        end else begin
            seen_q      <= seen_d;
            exp_q       <= exp_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            err_valid_q <= err_valid_d;
            err_src_q   <= err_src_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
        end
    end

    assign rx_ready  = ready_q;
    assign active    = active_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;
    assign err_valid = err_valid_q;
    assign err_src   = err_src_q;
    assign err_exp   = err_exp_q;
    assign err_got   = err_got_q;

endmodule

`default_nettype wire

// File: tb/tb_yc_niu_rx_sink.sv
//==============================================================================
//  Module   : tb_yc_niu_rx_sink
//  Purpose  : Self-checking bench for yc_niu_rx_sink. Three instances:
//             A - always-ready pattern (READY_ON=4, READY_OFF=0)
//             B - periodic pattern (READY_ON=2, READY_OFF=3)
//             C - narrow counters (CNT_W=3, SEQ_W=4) for saturation/wrap
//  Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_yc_niu_rx_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A ----------------
    logic        a_rst_n, a_en, a_valid;
    logic [63:0] a_flit;
    logic        a_ready, a_errv, a_act;
    logic [31:0] a_rxc;
    logic [15:0] a_errc, a_erre, a_errg;
    logic [1:0]  a_errs;

    yc_niu_rx_sink #(.READY_ON(4), .READY_OFF(0)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .rx_valid(a_valid), .rx_flit(a_flit),
        .rx_ready(a_ready), .rx_count(a_rxc), .err_count(a_errc), .err_valid(a_errv),
        .err_src(a_errs), .err_exp(a_erre), .err_got(a_errg), .active(a_act)
    );

    // ---------------- instance B ----------------
    logic        b_rst_n, b_en, b_valid;
    logic [63:0] b_flit;
    logic        b_ready, b_errv, b_act;
    logic [31:0] b_rxc;
    logic [15:0] b_errc, b_erre, b_errg;
    logic [1:0]  b_errs;

    yc_niu_rx_sink #(.READY_ON(2), .READY_OFF(3)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .rx_valid(b_valid), .rx_flit(b_flit),
        .rx_ready(b_ready), .rx_count(b_rxc), .err_count(b_errc), .err_valid(b_errv),
        .err_src(b_errs), .err_exp(b_erre), .err_got(b_errg), .active(b_act)
    );

    // ---------------- instance C ----------------
    logic        s_rst_n, s_en, s_valid;
    logic [63:0] s_flit;
    logic        s_ready, s_errv, s_act;
    logic [2:0]  s_rxc;
    logic [15:0] s_errc;
    logic [3:0]  s_erre, s_errg;
    logic [1:0]  s_errs;

    yc_niu_rx_sink #(.READY_ON(4), .READY_OFF(0), .CNT_W(3), .SEQ_W(4)) u_dut_c (
        .clk(clk), .rst_n(s_rst_n), .en(s_en), .rx_valid(s_valid), .rx_flit(s_flit),
        .rx_ready(s_ready), .rx_count(s_rxc), .err_count(s_errc), .err_valid(s_errv),
        .err_src(s_errs), .err_exp(s_erre), .err_got(s_errg), .active(s_act)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input int src, input int seq);
        logic [63:0] f;
        f        = '0;
        f[57:56] = src[1:0];
        f[15:0]  = seq[15:0];
        return f;
    endfunction

    // One row: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic        en;
        logic        valid;
        int          src;
        int          seq;
        logic        rdy;
        logic        act;
        logic [31:0] rxc;
        logic [15:0] errc;
        logic        errv;
        logic [1:0]  errs;
        logic [15:0] erre;
        logic [15:0] errg;
    } vec_t;

    function automatic vec_t v(input int en, input int valid, input int src, input int seq,
                               input int rdy, input int act, input int rxc, input int errc,
                               input int errv, input int errs, input int erre, input int errg);
        vec_t r;
        r.en    = en[0];
        r.valid = valid[0];
        r.src   = src;
        r.seq   = seq;
        r.rdy   = rdy[0];
        r.act   = act[0];
        r.rxc   = rxc;
        r.errc  = errc[15:0];
        r.errv  = errv[0];
        r.errs  = errs[1:0];
        r.erre  = erre[15:0];
        r.errg  = errg[15:0];
        return r;
    endfunction

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    logic [15:0] nxt;
    logic        rdy;
    int          bad;

    initial begin
        //        en v src seq      rdy act rxc errc errv errs erre errg
        vecs[0]  = v(1, 0, 0, 0,       1, 1,  0, 0, 0, 0, 0, 0);
        vecs[1]  = v(1, 1, 1, 5,       1, 1,  1, 0, 0, 0, 0, 0);
        vecs[2]  = v(1, 1, 1, 6,       1, 1,  2, 0, 0, 0, 0, 0);
        vecs[3]  = v(1, 1, 1, 8,       1, 1,  3, 1, 1, 1, 7, 8);
        vecs[4]  = v(1, 1, 1, 9,       1, 1,  4, 1, 1, 1, 7, 8);
        vecs[5]  = v(1, 1, 1, 20,      1, 1,  5, 2, 1, 1, 7, 8);
        vecs[6]  = v(1, 1, 2, 'hFFFE,  1, 1,  6, 2, 1, 1, 7, 8);
        vecs[7]  = v(1, 1, 2, 'hFFFF,  1, 1,  7, 2, 1, 1, 7, 8);
        vecs[8]  = v(1, 1, 2, 0,       1, 1,  8, 2, 1, 1, 7, 8);
        vecs[9]  = v(1, 1, 2, 1,       1, 1,  9, 2, 1, 1, 7, 8);
        vecs[10] = v(1, 1, 0, 0,       1, 1, 10, 2, 1, 1, 7, 8);
        vecs[11] = v(0, 1, 0, 1,       0, 0, 11, 2, 1, 1, 7, 8);
        vecs[12] = v(0, 1, 0, 2,       0, 0, 11, 2, 1, 1, 7, 8);
        vecs[13] = v(1, 1, 0, 2,       1, 1, 11, 2, 1, 1, 7, 8);
        vecs[14] = v(1, 1, 0, 2,       1, 1, 12, 2, 1, 1, 7, 8);
        vecs[15] = v(1, 0, 0, 3,       1, 1, 12, 2, 1, 1, 7, 8);
        vecs[16] = v(1, 1, 0, 7,       1, 1, 13, 3, 1, 1, 7, 8);

        a_rst_n = 1'b0; a_en = 1'b0; a_valid = 1'b0; a_flit = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_valid = 1'b0; b_flit = '0;
        s_rst_n = 1'b0; s_en = 1'b0; s_valid = 1'b0; s_flit = '0;
        repeat (2) tick();

        // ---------------- reset state ----------------
        check("reset rx_ready",  a_ready, 0);
        check("reset active",    a_act,   0);
        check("reset rx_count",  a_rxc,   0);
        check("reset err_count", a_errc,  0);
        check("reset err_valid", a_errv,  0);
        check("reset err_src",   a_errs,  0);
        check("reset err_exp",   a_erre,  0);
        check("reset err_got",   a_errg,  0);
        a_rst_n = 1'b1;

        // ---------------- table-driven vectors on A ----------------
        for (int i = 0; i < NVEC; i++) begin
            a_en    = vecs[i].en;
            a_valid = vecs[i].valid;
            a_flit  = mk(vecs[i].src, vecs[i].seq);
            tick();
            check($sformatf("row%0d rx_ready",  i), a_ready, vecs[i].rdy);
            check($sformatf("row%0d active",    i), a_act,   vecs[i].act);
            check($sformatf("row%0d rx_count",  i), a_rxc,   vecs[i].rxc);
            check($sformatf("row%0d err_count", i), a_errc,  vecs[i].errc);
            check($sformatf("row%0d err_valid", i), a_errv,  vecs[i].errv);
            check($sformatf("row%0d err_src",   i), a_errs,  vecs[i].errs);
            check($sformatf("row%0d err_exp",   i), a_erre,  vecs[i].erre);
            check($sformatf("row%0d err_got",   i), a_errg,  vecs[i].errg);
        end

        // ---------------- en dropped for 10 cycles, valid held high ----------------
        nxt = 16'd8;
        a_en = 1'b1; a_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_flit = mk(0, int'(nxt)); rdy = a_ready; tick(); if (rdy) nxt++;
        end
        check("endrop pre rx_count", a_rxc, 16);
        a_en = 1'b0;
        a_flit = mk(0, int'(nxt)); rdy = a_ready; tick(); if (rdy) nxt++;
        check("endrop fall-edge accept counted", a_rxc, 17);
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            if (a_ready !== 1'b0) bad++;
            a_flit = mk(0, int'(nxt)); rdy = a_ready; tick(); if (rdy) nxt++;
        end
        if (a_ready !== 1'b0) bad++;
        check("endrop ready high cycles", bad, 0);
        check("endrop rx_count held", a_rxc, 17);
        a_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_flit = mk(0, int'(nxt)); rdy = a_ready; tick(); if (rdy) nxt++;
        end
        check("endrop resume rx_count", a_rxc, 21);
        check("endrop resume err_count", a_errc, 3);
        check("endrop resume rx_ready", a_ready, 1);

        // ---------------- reset, then source 0 sends 0..99 ----------------
        a_valid = 1'b0; a_rst_n = 1'b0;
        repeat (2) tick();
        a_rst_n = 1'b1; a_en = 1'b1;
        tick();
        check("stream100 ready after 1 cycle", a_ready, 1);
        nxt = 16'd0; bad = 0;
        a_valid = 1'b1;
        while (nxt < 16'd100 && bad < 200) begin
            if (a_ready !== 1'b1) bad++;
            a_flit = mk(0, int'(nxt)); rdy = a_ready; tick(); if (rdy) nxt++;
        end
        check("stream100 ready low cycles", bad, 0);
        check("stream100 rx_count", a_rxc, 100);
        check("stream100 err_count", a_errc, 0);
        check("stream100 err_valid", a_errv, 0);

        // ---------------- reset mid-stream, resume at seq 50 ----------------
        a_flit = mk(0, 100); a_rst_n = 1'b0;
        tick();
        check("midrst rx_count", a_rxc, 0);
        check("midrst err_count", a_errc, 0);
        check("midrst rx_ready", a_ready, 0);
        check("midrst active", a_act, 0);
        a_rst_n = 1'b1;
        a_flit = mk(0, 50);
        tick();
        check("midrst ready rises", a_ready, 1);
        check("midrst no accept while idle", a_rxc, 0);
        tick();
        check("midrst seed rx_count", a_rxc, 1);
        check("midrst seed err_count", a_errc, 0);
        check("midrst seed err_valid", a_errv, 0);
        a_flit = mk(0, 51);
        tick();
        check("midrst next rx_count", a_rxc, 2);
        check("midrst next err_count", a_errc, 0);
        a_valid = 1'b0;

        // ---------------- B: periodic 11000 pattern over 1000 cycles ----------------
        b_rst_n = 1'b1; b_en = 1'b1;
        tick();
        check("periodic ready first rise", b_ready, 1);
        nxt = 16'd0; bad = 0;
        b_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (b_ready !== ((i % 5) < 2)) bad++;
            b_flit = mk(3, int'(nxt)); rdy = b_ready; tick(); if (rdy) nxt++;
        end
        b_valid = 1'b0;
        check("periodic pattern mismatches", bad, 0);
        check("periodic rx_count", b_rxc, 400);
        check("periodic err_count", b_errc, 0);
        check("periodic err_valid", b_errv, 0);

        // ---------------- C: 4-bit sequence wrap and 3-bit count saturation ----------------
        s_rst_n = 1'b1; s_en = 1'b1;
        tick();
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_flit = mk(3, (12 + i) % 16);
            tick();
        end
        check("narrow rx_count saturated", s_rxc, 7);
        check("narrow wrap err_count", s_errc, 0);
        check("narrow wrap err_valid", s_errv, 0);
        s_flit = mk(3, 9);
        tick();
        s_valid = 1'b0;
        check("narrow err_count", s_errc, 1);
        check("narrow err_valid", s_errv, 1);
        check("narrow err_src", s_errs, 3);
        check("narrow err_exp", s_erre, 6);
        check("narrow err_got", s_errg, 9);
        check("narrow rx_count still saturated", s_rxc, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
